// File: rtl/stp_deser.sv
// stp_deser: serial-to-parallel deserializer with a registered ready/valid output
// and a sticky overflow flag. Each beat shifts LANES bits into the shift register.
// NUM_BITS/LANES beats form one word.
// Optional feature macro STP_PARITY_EN: every word is followed by one extra beat.
// That beat carries an even-parity bit on serial_in[0], and the result is reported
// on parity_err.
module stp_deser #(
    parameter int unsigned NUM_BITS  = 128,
    parameter int unsigned LANES     = 1,
    parameter int unsigned SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_enable,
    input  logic [LANES-1:0]    serial_in,
    input  logic                clear,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                out_valid,
    output logic                overflow,
    output logic                parity_err
);

    localparam int unsigned NumBeats = NUM_BITS / LANES;
    localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

    if (!((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8)) ||
        (NUM_BITS < LANES) || ((NUM_BITS % LANES) != 0)) begin : gen_param_check
        $error("stp_deser: LANES must be 1, 2, 4 or 8 and divide NUM_BITS");
    end

    logic [NUM_BITS-1:0] sr_q, sr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_BITS-1:0] pout_q, pout_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic [NUM_BITS-1:0] shifted;
    logic [NUM_BITS-1:0] word;
    logic                complete;
    logic                load;
    logic                last_beat;

    assign last_beat = (cnt_q == LastBeat);

    // Shift-register value after accepting serial_in as a data beat.
    always_comb begin
        if (SHIFT_MSB != 0) begin
            shifted = (sr_q << LANES) | NUM_BITS'(serial_in);
        end else begin
            shifted = (sr_q >> LANES) | (NUM_BITS'(serial_in) << (NUM_BITS - LANES));
        end
    end

`ifdef STP_PARITY_EN
    typedef enum logic [0:0] {StFill, StPar} state_e;

    state_e state_q, state_d;
    logic   perr_q, perr_d;
    logic   word_par;

    // Beat sequencing: data beats in StFill, then a single parity beat in StPar.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        complete = 1'b0;
        word     = sr_q;
        word_par = 1'b0;
        if (clear) begin
            state_d = StFill;
            cnt_d   = '0;
            sr_d    = '0;
        end else if (shift_enable) begin
            unique case (state_q)
                StFill: begin
                    sr_d = shifted;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = StPar;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StPar: begin
                    state_d  = StFill;
                    complete = 1'b1;
                    // Odd total ones (data plus parity bit) flags an error.
                    word_par = (^sr_q) ^ serial_in[0];
                end
                default: state_d = StFill;
            endcase
        end
    end

    // Parity state and parity result, loaded together with parallel_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            perr_q  <= perr_d;
        end
    end

    assign perr_d     = load ? word_par : perr_q;
    assign parity_err = perr_q;
`else
    // Beat sequencing: the word completes on the last data beat itself.
    always_comb begin
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        complete = 1'b0;
        word     = shifted;
        if (clear) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (shift_enable) begin
            sr_d = shifted;
            if (last_beat) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign parity_err = 1'b0;
`endif

    // Output handshake: load a completed word, drop it into overflow, or consume.
    always_comb begin
        load    = complete && (!valid_q || out_ready);
        pout_d  = load ? word : pout_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (complete && !load) begin
            ovf_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_stp_deser.sv
// Bench for stp_deser: an 8-bit LSB-first instance checked against a bit-queue
// model, and a 128-bit 4-lane MSB-first instance checked with computed words.
module tb_stp_deser;

`ifdef STP_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic       se8, si8, clr8, rdy8;
    logic [7:0] po8;
    logic       ov8, of8, pe8;

    logic         se128, clr128, rdy128;
    logic [3:0]   si128;
    logic [127:0] po128;
    logic         ov128, of128, pe128;

    int n_checks = 0;
    int n_errors = 0;

    stp_deser #(.NUM_BITS(8), .LANES(1), .SHIFT_MSB(0)) dut8 (
        .clk(clk), .rst(rst), .shift_enable(se8), .serial_in(si8), .clear(clr8),
        .out_ready(rdy8), .parallel_out(po8), .out_valid(ov8), .overflow(of8),
        .parity_err(pe8)
    );

    stp_deser #(.NUM_BITS(128), .LANES(4), .SHIFT_MSB(1)) dut128 (
        .clk(clk), .rst(rst), .shift_enable(se128), .serial_in(si128), .clear(clr128),
        .out_ready(rdy128), .parallel_out(po128), .out_valid(ov128), .overflow(of128),
        .parity_err(pe128)
    );

    always #5 clk = ~clk;

    // Reference model for dut8: collected bits in arrival order, output slot.
    logic       m_bits[$];
    logic [7:0] m_pout;
    logic       m_valid, m_ovf, m_perr;

    task automatic model_reset();
        m_bits.delete();
        m_pout  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_edge(input logic se, input logic si, input logic clr, input logic rdy);
        logic       comp;
        logic [7:0] w;
        logic       p;
        comp = 1'b0;
        w    = 8'h00;
        p    = 1'b0;
        if (clr) begin
            m_bits.delete();
        end else if (se) begin
            if (PAR_EN && m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) w[i] = m_bits[i];
                p    = (^w) ^ si;
                comp = 1'b1;
                m_bits.delete();
            end else begin
                m_bits.push_back(si);
                if (!PAR_EN && m_bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) w[i] = m_bits[i];
                    comp = 1'b1;
                    m_bits.delete();
                end
            end
        end
        if (comp) begin
            if (!m_valid || rdy) begin
                m_pout  = w;
                m_perr  = p;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (clr) m_ovf = 1'b0;
    endtask

    // One clock of dut8 stimulus; returns 1 time unit after the rising edge.
    task automatic cyc8(input logic se, input logic si, input logic clr, input logic rdy);
        se8 = se; si8 = si; clr8 = clr; rdy8 = rdy;
        @(posedge clk);
        model_edge(se, si, clr, rdy);
        #1;
    endtask

    task automatic cyc128(input logic se, input logic [3:0] si, input logic clr, input logic rdy);
        se128 = se; si128 = si; clr128 = clr; rdy128 = rdy;
        @(posedge clk);
        #1;
    endtask

    // Feeds one full word LSB first, plus the parity beat when enabled.
    task automatic feed_word8(input logic [7:0] w, input logic par, input logic rdy);
        for (int i = 0; i < 8; i++) cyc8(1'b1, w[i], 1'b0, rdy);
        if (PAR_EN) cyc8(1'b1, par, 1'b0, rdy);
    endtask

    task automatic test_reset();
        n_checks++; if (po8 !== 8'h00) begin n_errors++; $display("FAIL reset_po8 got %h want 00", po8); end
        n_checks++; if (ov8 !== 1'b0) begin n_errors++; $display("FAIL reset_ov8 got %b want 0", ov8); end
        n_checks++; if (of8 !== 1'b0) begin n_errors++; $display("FAIL reset_of8 got %b want 0", of8); end
        n_checks++; if (pe8 !== 1'b0) begin n_errors++; $display("FAIL reset_pe8 got %b want 0", pe8); end
        n_checks++; if (po128 !== 128'h0) begin n_errors++; $display("FAIL reset_po128 got %h want 0", po128); end
        n_checks++; if ({ov128, of128, pe128} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags128 got %b want 000", {ov128, of128, pe128});
        end
    endtask

    task automatic test_basic_word();
        logic [7:0] w;
        w = 8'h4D;
        for (int i = 0; i < 7; i++) cyc8(1'b1, w[i], 1'b0, 1'b0);
        if (PAR_EN) cyc8(1'b1, w[7], 1'b0, 1'b0);
        n_checks++; if (ov8 !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid got %b want 0", ov8); end
        cyc8(1'b1, PAR_EN ? 1'b0 : w[7], 1'b0, 1'b0);
        n_checks++; if (ov8 !== 1'b1) begin n_errors++; $display("FAIL basic_valid got %b want 1", ov8); end
        n_checks++; if (po8 !== 8'h4D) begin n_errors++; $display("FAIL basic_word got %h want 4d", po8); end
        n_checks++; if (pe8 !== 1'b0) begin n_errors++; $display("FAIL basic_perr got %b want 0", pe8); end
        cyc8(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (ov8 !== 1'b0) begin n_errors++; $display("FAIL basic_consume got %b want 0", ov8); end
    endtask

    task automatic test_overflow();
        feed_word8(8'h4D, 1'b0, 1'b0);
        feed_word8(8'hFF, 1'b0, 1'b0);
        n_checks++; if (po8 !== 8'h4D) begin n_errors++; $display("FAIL ovf_word got %h want 4d", po8); end
        n_checks++; if ({ov8, of8} !== 2'b11) begin n_errors++; $display("FAIL ovf_flags got %b want 11", {ov8, of8}); end
        cyc8(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({ov8, of8} !== 2'b10) begin n_errors++; $display("FAIL ovf_clear got %b want 10", {ov8, of8}); end
        n_checks++; if (po8 !== 8'h4D) begin n_errors++; $display("FAIL ovf_clear_word got %h want 4d", po8); end
        cyc8(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_abort();
        for (int i = 0; i < 3; i++) cyc8(1'b1, 1'b1, 1'b0, 1'b0);
        cyc8(1'b1, 1'b1, 1'b1, 1'b0);
        feed_word8(8'hA5, 1'b0, 1'b0);
        n_checks++; if (po8 !== 8'hA5) begin n_errors++; $display("FAIL abort_word got %h want a5", po8); end
        n_checks++; if ({ov8, of8} !== 2'b10) begin n_errors++; $display("FAIL abort_flags got %b want 10", {ov8, of8}); end
        cyc8(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        feed_word8(8'h3C, 1'b0, 1'b0);
        feed_word8(8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc8(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++; if ({po8, ov8, of8, pe8} !== 11'h0) begin
            n_errors++; $display("FAIL async_reset got %h/%b%b%b want 00/000", po8, ov8, of8, pe8);
        end
        #3;
        rst = 1'b0;
        model_reset();
        w = 8'($urandom);
        feed_word8(w, ^w, 1'b0);
        n_checks++; if (po8 !== w) begin n_errors++; $display("FAIL post_reset_word got %h want %h", po8, w); end
        n_checks++; if ({ov8, pe8} !== 2'b10) begin n_errors++; $display("FAIL post_reset_flags got %b want 10", {ov8, pe8}); end
        cyc8(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef STP_PARITY_EN
    task automatic test_parity();
        feed_word8(8'h4D, 1'b0, 1'b0);
        n_checks++; if ({ov8, pe8} !== 2'b10) begin n_errors++; $display("FAIL parity_ok got %b want 10", {ov8, pe8}); end
        cyc8(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc8(1'b1, 1'(8'h4D >> i), 1'b0, 1'b0);
        n_checks++; if (ov8 !== 1'b0) begin n_errors++; $display("FAIL parity_8th_beat got %b want 0", ov8); end
        cyc8(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if ({ov8, pe8} !== 2'b11) begin n_errors++; $display("FAIL parity_bad got %b want 11", {ov8, pe8}); end
        n_checks++; if (po8 !== 8'h4D) begin n_errors++; $display("FAIL parity_word got %h want 4d", po8); end
        cyc8(1'b0, 1'b0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            cyc8(1'b1, 1'($urandom_range(1)), 1'b0, 1'b1);
            n_checks++;
            if ({po8, ov8, of8, pe8} !== {m_pout, m_valid, m_ovf, m_perr}) begin
                n_errors++;
                $display("FAIL b2b cycle %0d got %h/%b%b%b want %h/%b%b%b", c, po8, ov8, of8, pe8,
                         m_pout, m_valid, m_ovf, m_perr);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            cyc8($urandom_range(9) < 7, 1'($urandom_range(1)), $urandom_range(49) == 0,
                 1'($urandom_range(1)));
            n_checks++;
            if ({po8, ov8, of8, pe8} !== {m_pout, m_valid, m_ovf, m_perr}) begin
                n_errors++;
                $display("FAIL random cycle %0d got %h/%b%b%b want %h/%b%b%b", c, po8, ov8, of8, pe8,
                         m_pout, m_valid, m_ovf, m_perr);
            end
        end
        cyc8(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wide128();
        logic [127:0] exp;
        logic [3:0]   nib;
        exp = 128'h0123456789ABCDEF0123456789ABCDEF;
        for (int k = 0; k < 32; k++) cyc128(1'b1, 4'(k % 16), 1'b0, 1'b0);
        if (PAR_EN) cyc128(1'b1, {3'b000, ^exp}, 1'b0, 1'b0);
        n_checks++; if (po128 !== exp) begin n_errors++; $display("FAIL wide_word got %h want %h", po128, exp); end
        n_checks++; if ({ov128, of128, pe128} !== 3'b100) begin
            n_errors++; $display("FAIL wide_flags got %b want 100", {ov128, of128, pe128});
        end
        cyc128(1'b0, 4'h0, 1'b0, 1'b1);
        n_checks++; if (ov128 !== 1'b0) begin n_errors++; $display("FAIL wide_consume got %b want 0", ov128); end
        exp = '0;
        for (int k = 0; k < 32; k++) begin
            nib = 4'($urandom);
            exp[127 - 4 * k -: 4] = nib;
            cyc128(1'b1, nib, 1'b0, 1'b0);
        end
        if (PAR_EN) cyc128(1'b1, {3'b000, ^exp}, 1'b0, 1'b0);
        n_checks++; if (po128 !== exp) begin n_errors++; $display("FAIL wide_rand got %h want %h", po128, exp); end
        n_checks++; if ({ov128, pe128} !== 2'b10) begin
            n_errors++; $display("FAIL wide_rand_flags got %b want 10", {ov128, pe128});
        end
    endtask

    initial begin
        rst = 1'b1;
        se8 = 1'b0; si8 = 1'b0; clr8 = 1'b0; rdy8 = 1'b0;
        se128 = 1'b0; si128 = 4'h0; clr128 = 1'b0; rdy128 = 1'b0;
        model_reset();
        #3;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_basic_word();
        test_overflow();
        test_clear_abort();
        test_reset_midword();
`ifdef STP_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_random();
        test_wide128();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stp_deser.md
STP_DESER -- requirements
Module: stp_deser

Interface
REQ-001 Parameter NUM_BITS, default 128: width of the assembled parallel word.
REQ-002 Parameter LANES, default 1: serial bits accepted per beat; SHALL be 1, 2, 4 or 8 and SHALL divide NUM_BITS (elaboration error otherwise).
REQ-003 Parameter SHIFT_MSB, default 0: 0 = first beat lands in LSBs, 1 = first beat lands in MSBs.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 shift_enable  input  1  beat strobe; serial_in is sampled when high.
REQ-007 serial_in  input  LANES  serial data for one beat; bit 0 is the earliest bit within the beat.
REQ-008 clear  input  1  synchronous abort of the partial word and the overflow flag.
REQ-009 out_ready  input  1  consumer accepts parallel_out this cycle.
REQ-010 parallel_out  output  NUM_BITS  registered completed word.
REQ-011 out_valid  output  1  parallel_out holds an unconsumed word.
REQ-012 overflow  output  1  sticky flag: a completed word was dropped.
REQ-013 parity_err  output  1  parity result for the word in parallel_out (STP_PARITY_EN only; tied 0 otherwise).

Function
REQ-014 The beat counter SHALL count 0..NUM_BITS/LANES-1 and increment only when shift_enable=1.
REQ-015 SHIFT_MSB=0: each beat SHALL shift the register right by LANES and insert serial_in at the top, so beat 0 ends at [LANES-1:0].
REQ-016 SHIFT_MSB=1: each beat SHALL shift the register left by LANES and insert serial_in at the bottom, so beat 0 ends at the MSBs.
REQ-017 States: FILL (collecting data beats) and, with STP_PARITY_EN, PAR (one parity beat); FILL->PAR on the last data beat; PAR->FILL on the parity beat.
REQ-018 The word SHALL complete on the last beat (last data beat, or the parity beat when STP_PARITY_EN is defined); parallel_out and out_valid SHALL update at that same clock edge (visible one cycle after the beat).
REQ-019 out_valid SHALL clear on a cycle where out_valid=1 and out_ready=1 with no completion.
REQ-020 Completion with out_valid=0, or with out_valid=1 and out_ready=1: load the new word and keep or set out_valid=1 (no bubble).
REQ-021 Completion with out_valid=1 and out_ready=0: drop the new word, leave parallel_out unchanged, set overflow=1.
REQ-022 The counter SHALL wrap to 0 after completion; the next beat starts a new word with no dead cycle.
REQ-023 clear=1 SHALL zero the counter, return to FILL, discard any beat in the same cycle and clear overflow; parallel_out and out_valid SHALL be unaffected.
REQ-024 parallel_out SHALL be stable while out_valid=1 until it is consumed.

Reset
REQ-025 rst=1 SHALL asynchronously force parallel_out=0, out_valid=0, overflow=0, parity_err=0, counter=0, state=FILL and the shift register to 0, including when a word is partially collected.
REQ-026 After rst deasserts, the first shift_enable beat SHALL be treated as beat 0.

Configuration
REQ-027 Macro STP_PARITY_EN defined: each word is followed by one parity beat with the parity bit on serial_in[0] (other lanes ignored).
REQ-028 With STP_PARITY_EN, parity_err SHALL be 1 when the data bits plus the parity bit contain an odd number of ones (even parity).
REQ-029 parity_err SHALL be registered with parallel_out and follow the same load and drop rules.
REQ-030 Macro STP_PARITY_EN undefined: there is no PAR state and parity_err is constant 0.

Verification
REQ-031 NUM_BITS=8, LANES=1, SHIFT_MSB=0, bits 1,0,1,1,0,0,1,0 -> parallel_out=8'h4D, out_valid=1 one cycle after the 8th beat.
REQ-032 NUM_BITS=128, LANES=4, SHIFT_MSB=1, 32 nibbles 0,1,...,F,0,...,F -> parallel_out=128'h0123456789ABCDEF0123456789ABCDEF.
REQ-033 NUM_BITS=8, out_ready=0, words 0x4D then 0xFF -> parallel_out=0x4D, overflow=1; then clear -> overflow=0, out_valid still 1.
REQ-034 NUM_BITS=8, 3 beats, then clear, then 8 beats of 0xA5 -> parallel_out=0xA5 with no residue from the aborted beats.
REQ-035 NUM_BITS=8, rst pulsed after 5 beats -> all outputs 0 immediately; the next 8 beats produce a correct word.
REQ-036 STP_PARITY_EN, NUM_BITS=8, word 0x4D with parity 0 -> parity_err=0; word 0x4D with parity 1 -> parity_err=1; each word completes on the 9th beat.
